// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, sequencer states and default widths for the accumulator CPU
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;
  typedef enum logic [2:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_OPERAND, S_EXEC, S_HALT
  } state_t;
endpackage

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer holding pc, ir, acc, mdr and z;
// masters the unified memory port and drives the external ALU.
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              halted
);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_pc, w_addr_f, w_mem_addr;
  logic [DATA_W-1:0] r_ir, r_acc, r_mdr;
  logic r_z, w_re, w_we, w_mem_op;
  logic [3:0] w_op;
  assign w_op = r_ir[DATA_W-1 -: 4];
  assign w_addr_f = r_ir[ADDR_W-1:0];
  assign w_mem_op = (w_op >= OP_ADD && w_op <= OP_XOR) || w_op == OP_LOAD;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_acc <= '0;
      r_mdr <= '0;
      r_z <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FETCH_WAIT: begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + 1'b1;
        end
        S_DECODE: if (w_op == OP_JMP || (w_op == OP_JZ && r_z)) r_pc <= w_addr_f;
        S_OPERAND: r_mdr <= mem_rdata;
        S_EXEC: begin
          r_acc <= w_op == OP_LOAD ? r_mdr : alu_result;
          r_z <= w_op == OP_LOAD ? r_mdr == '0 : alu_zero;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    w_next = r_state;
    w_re = 1'b0;
    w_we = 1'b0;
    w_mem_addr = r_pc;
    alu_op = OP_NOP;
    alu_b = r_mdr;
    case (r_state)
      S_FETCH: begin
        w_next = S_FETCH_WAIT;
        w_re = 1'b1;
      end
      S_FETCH_WAIT: w_next = S_DECODE;
      S_DECODE: begin
        w_next = w_mem_op ? S_OPERAND : w_op == OP_NOT ? S_EXEC : w_op == OP_HALT ? S_HALT : S_FETCH;
        w_re = w_mem_op;
        w_we = w_op == OP_STORE;
        w_mem_addr = (w_mem_op || w_op == OP_STORE) ? w_addr_f : r_pc;
      end
      S_OPERAND: w_next = S_EXEC;
      S_EXEC: begin
        w_next = S_FETCH;
        alu_op = w_op;
        alu_b = w_op == OP_NOT ? '0 : r_mdr;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end
  // strobes gated by reset so an interrupted STORE never reaches memory
  assign mem_re = w_re & rst_n;
  assign mem_we = w_we & rst_n;
  assign mem_addr = w_mem_addr;
  assign mem_wdata = r_acc;
  assign alu_a = r_acc;
  assign pc = r_pc;
  assign acc = r_acc;
  assign halted = r_state == S_HALT;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector table, corner sequences and random programs
// checked against an instruction-level reference model.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] mem_addr, pc;
  logic mem_re, mem_we, halted;
  logic [15:0] mem_wdata, mem_rdata, alu_a, alu_b, alu_result, acc;
  logic [3:0] alu_op;
  logic alu_zero;
  logic [11:0] mem_addr2, pc2;
  logic mem_re2, mem_we2, halted2;
  logic [15:0] mem_wdata2, alu_a2, alu_b2, acc2;
  logic [3:0] alu_op2;
  logic [15:0] mem [4096];
  logic [15:0] ref_mem [4096];
  logic [15:0] m_acc;
  logic [11:0] m_pc;
  logic m_z, m_halt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  control_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero), .pc(pc), .acc(acc),
    .halted(halted)
  );
  control_unit #(.RESET_PC(12'hFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr2), .mem_re(mem_re2), .mem_we(mem_we2),
    .mem_wdata(mem_wdata2), .mem_rdata(16'h0000), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_op(alu_op2), .alu_result(16'h0000), .alu_zero(1'b0), .pc(pc2), .acc(acc2),
    .halted(halted2)
  );
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end
  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      4'h1: alu_result = alu_a + alu_b;
      4'h2: alu_result = alu_a - alu_b;
      4'h3: alu_result = alu_a & alu_b;
      4'h4: alu_result = alu_a | alu_b;
      4'h5: alu_result = alu_a ^ alu_b;
      4'h6: alu_result = ~alu_a;
      default: ;
    endcase
  end
  assign alu_zero = alu_result == 16'h0000;
  typedef struct {
    logic [15:0] p0, p1, p2, p3, d0, d1;
    int cyc;
    logic [15:0] acc;
    logic [11:0] pc;
    logic [15:0] m12;
  } vec_t;
  vec_t vt [8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // instruction-level model: one loop iteration per instruction, cycle cost summed
  task automatic run_model(input int n, output int cyc);
    logic [15:0] ir, opnd;
    logic [3:0] op;
    logic [11:0] a;
    cyc = 0;
    for (int i = 0; i < n && !m_halt; i++) begin
      ir = ref_mem[m_pc];
      m_pc = m_pc + 12'd1;
      op = ir[15:12];
      a = ir[11:0];
      opnd = ref_mem[a];
      cyc += (op >= 4'h1 && op <= 4'h5) || op == 4'h7 ? 5 : op == 4'h6 ? 4 : 3;
      case (op)
        4'h1: m_acc = m_acc + opnd;
        4'h2: m_acc = m_acc - opnd;
        4'h3: m_acc = m_acc & opnd;
        4'h4: m_acc = m_acc | opnd;
        4'h5: m_acc = m_acc ^ opnd;
        4'h6: m_acc = ~m_acc;
        4'h7: m_acc = opnd;
        4'h8: ref_mem[a] = m_acc;
        4'h9: m_pc = a;
        4'hA: if (m_z) m_pc = a;
        4'hF: m_halt = 1'b1;
        default: ;
      endcase
      if (op >= 4'h1 && op <= 4'h7) m_z = m_acc == 16'h0000;
    end
  endtask
  initial begin
    int mre_cnt, cyc;
    vt[0] = '{16'h7010, 16'h1011, 16'h8012, 16'h0000, 16'd9, 16'd3, 13, 16'd12, 12'h003, 16'd12};
    vt[1] = '{16'h7010, 16'h2011, 16'hA020, 16'h0000, 16'd5, 16'd5, 13, 16'd0, 12'h020, 16'd0};
    vt[2] = '{16'h7010, 16'h2011, 16'hA020, 16'h0000, 16'd5, 16'd3, 13, 16'd2, 12'h003, 16'd0};
    vt[3] = '{16'h7010, 16'h3011, 16'h0000, 16'h0000, 16'h000F, 16'h0007, 10, 16'h0007, 12'h002, 16'd0};
    vt[4] = '{16'h7010, 16'h4011, 16'h0000, 16'h0000, 16'h000F, 16'h0007, 10, 16'h000F, 12'h002, 16'd0};
    vt[5] = '{16'h7010, 16'h5011, 16'h0000, 16'h0000, 16'h000F, 16'h0007, 10, 16'h0008, 12'h002, 16'd0};
    vt[6] = '{16'h7010, 16'h6000, 16'h0000, 16'h0000, 16'h000F, 16'h0000, 9, 16'hFFF0, 12'h002, 16'd0};
    vt[7] = '{16'hC000, 16'h7010, 16'h0000, 16'h0000, 16'd5, 16'd0, 8, 16'd5, 12'h002, 16'd0};
    clear_mem();
    mem[0] = 16'h8012;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_we", mem_we, 0);
      chk("rst_re", mem_re, 0);
    end
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_halted", halted, 0);
    rst_n = 1'b1;
    #1;
    chk("first_re", mem_re, 1);
    chk("first_addr", mem_addr, 0);
    chk("wrap_first_addr", mem_addr2, 12'hFFF);
    chk("wrap_first_re", mem_re2, 1);
    step(3);
    chk("wrap_next_addr", mem_addr2, 12'h000);
    chk("wrap_next_re", mem_re2, 1);
    chk("wrap_pc", pc2, 12'h000);
    for (int i = 0; i < 8; i++) begin
      clear_mem();
      mem[0] = vt[i].p0; mem[1] = vt[i].p1; mem[2] = vt[i].p2; mem[3] = vt[i].p3;
      mem[16] = vt[i].d0; mem[17] = vt[i].d1;
      do_reset();
      step(vt[i].cyc);
      chk($sformatf("vec%0d_acc", i), acc, vt[i].acc);
      chk($sformatf("vec%0d_pc", i), pc, vt[i].pc);
      chk($sformatf("vec%0d_m12", i), mem[18], vt[i].m12);
      chk($sformatf("vec%0d_fetch", i), {mem_re, 4'h0, mem_addr}, {1'b1, 4'h0, vt[i].pc});
    end
    clear_mem();
    mem[0] = 16'h7010; mem[1] = 16'h1011; mem[16] = 16'd9; mem[17] = 16'd3;
    do_reset();
    step(9);
    chk("add_exec_op", alu_op, 4'h1);
    chk("add_exec_a", alu_a, 16'd9);
    chk("add_exec_b", alu_b, 16'd3);
    clear_mem();
    mem[0] = 16'h7010; mem[1] = 16'h6000; mem[16] = 16'h000F;
    do_reset();
    step(8);
    chk("not_exec_op", alu_op, 4'h6);
    chk("not_exec_b", alu_b, 16'h0000);
    clear_mem();
    mem[0] = 16'h7010; mem[1] = 16'hF000; mem[16] = 16'd4;
    do_reset();
    step(8);
    chk("halt_flag", halted, 1);
    mre_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (mem_re) mre_cnt++;
    end
    chk("halt_no_re", mre_cnt, 0);
    chk("halt_still", halted, 1);
    chk("halt_pc", pc, 12'h002);
    clear_mem();
    mem[0] = 16'h8012;
    do_reset();
    step(2);
    chk("store_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("store_we_gated", mem_we, 0);
    step(1);
    rst_n = 1'b1;
    #1;
    chk("store_abort_mem", mem[18], 16'h0000);
    clear_mem();
    mem[0] = 16'h1010; mem[16] = 16'd7;
    do_reset();
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    #1;
    chk("midrst_acc", acc, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_fetch", {mem_re, 4'h0, mem_addr}, {1'b1, 16'h0000});
    step(5);
    chk("midrst_rerun_acc", acc, 16'd7);
    for (int t = 0; t < 6; t++) begin
      clear_mem();
      for (int i = 0; i < 31; i++) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 14));
        mem[i] = {op, (op == 4'h9 || op == 4'hA) ? 12'($urandom_range(0, 30)) : 12'(12'h040 + $urandom_range(0, 15))};
      end
      mem[31] = 16'h9000;
      for (int i = 0; i < 16; i++) begin
        int k;
        k = $urandom_range(0, 3);
        mem[64 + i] = k == 0 ? 16'h0000 : k == 1 ? 16'h0001 : k == 2 ? 16'hFFFF : 16'($urandom);
      end
      for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
      m_acc = 16'h0000; m_pc = 12'h000; m_z = 1'b0; m_halt = 1'b0;
      run_model(40, cyc);
      do_reset();
      step(cyc);
      chk($sformatf("rnd%0d_acc", t), acc, m_acc);
      chk($sformatf("rnd%0d_pc", t), pc, m_pc);
      chk($sformatf("rnd%0d_halted", t), halted, m_halt);
      for (int i = 64; i < 80; i++) chk($sformatf("rnd%0d_mem%0d", t, i), mem[i], ref_mem[i]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Fetch/decode/execute sequencer for the 16-bit accumulator processor, driving the opposite side of the ALU interface: it supplies operands and a 4-bit opcode to `ALU`, then consumes `result` and `zero`. It also masters the single shared (Von Neumann) instruction/data memory port. It sits in `cpu_top` between the unified memory and the ALU and holds `pc`, `ir`, `acc`, `mdr` and the zero flag.

## Interface
- `DATA_W`, 16: data, instruction and ALU width.
- `ADDR_W`, 12: memory address width; equals the instruction address field.
- `RESET_PC`, 0: `pc` value after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_re`  out  1  read strobe; data is returned in `mem_rdata` on the next cycle.
- `mem_we`  out  1  write strobe; the write commits at the edge ending the cycle.
- `mem_wdata`  out  DATA_W  write data (always `acc`).
- `mem_rdata`  in  DATA_W  read data, valid in the cycle after `mem_re`.
- `alu_a`, `alu_b`  out  DATA_W  ALU operands (`num1`, `num2`).
- `alu_op`  out  4  ALU opcode.
- `alu_result`  in  DATA_W  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `pc`, `acc`  out  ADDR_W / DATA_W  architectural state, for debug.
- `halted`  out  1  high while in HALT.

## Operation
- Instruction format: `[15:12]` opcode, `[11:0]` address `A`.
- Opcodes:
  - 0000 NOP
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR: `acc <= acc op M[A]`
  - 0110 NOT: `acc <= ~acc`
  - 0111 LOAD: `acc <= M[A]`
  - 1000 STORE: `M[A] <= acc`
  - 1001 JMP: `pc <= A`
  - 1010 JZ: `pc <= A` if `z` = 1
  - 1111 HALT
  - 1011–1110 execute as NOP.
- ALU opcodes 0001–0110 are passed to `alu_op` unchanged.
- States:
  - FETCH: `mem_addr=pc`, `mem_re=1`. Next: FETCH_WAIT.
  - FETCH_WAIT: `ir <= mem_rdata`; `pc <= pc+1`, wrapping modulo 2^ADDR_W (0xFFF→0x000). Next: DECODE.
  - DECODE, by opcode:
    - ALU binary ops and LOAD: `mem_addr=A`, `mem_re=1`. Next: OPERAND.
    - NOT: next EXEC.
    - STORE: `mem_addr=A`, `mem_we=1`. Next: FETCH.
    - JMP/JZ: update `pc` as above. Next: FETCH.
    - HALT: next HALT.
    - All others: next FETCH.
  - OPERAND: `mdr <= mem_rdata`. Next: EXEC.
  - EXEC:
    - `alu_a=acc`, `alu_b=mdr` (NOT: `alu_b=0`), `alu_op=ir[15:12]`.
    - `acc <= alu_result`, `z <= alu_zero`.
    - LOAD bypasses the ALU: `acc <= mdr`, `z <= (mdr==0)`.
    - Next: FETCH.
  - HALT: no memory access; `halted=1`. Only reset exits this state.
- `z` changes only in EXEC. Results wrap modulo 2^16; there is no carry or overflow flag.
- JZ tests `z` as it stands in DECODE, i.e. the flag from the most recent ALU or LOAD instruction.
- Outside the states listed above, outputs idle: `mem_re=0`, `mem_we=0`, `mem_addr=pc`, `alu_op=0000`, `alu_a=acc`, `alu_b=mdr`.

## Timing
- Cycles per instruction:
  - 3: NOP, STORE, JMP, JZ (taken or not), undefined opcodes.
  - 4: NOT.
  - 5: ADD, SUB, AND, OR, XOR, LOAD.
- Memory read latency is exactly 1 cycle; there is no wait-state handshake.
- A STORE at `A` followed by a read of `A` returns the new value, because the write commits before the next FETCH.
- Reset values: `pc=RESET_PC`; `acc`, `ir`, `mdr` = 0; `z=0`; state FETCH; `halted=0`.
- The first FETCH (`mem_re=1`, `mem_addr=RESET_PC`) occurs in the first cycle with `rst_n`=1.
- `mem_re` and `mem_we` are ANDed with `rst_n`, so no access is issued in any cycle with `rst_n`=0, including a STORE interrupted mid-instruction.
- Reset mid-instruction abandons the instruction: no `acc`, `z` or `pc` update from it survives.
- Self-modifying code is legal: a STORE to `pc`'s address is fetched afterwards.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (`OP_NOP` … `OP_HALT`), reused by `ALU` and the benches;
  - the state encoding (`S_FETCH`, `S_FETCH_WAIT`, `S_DECODE`, `S_OPERAND`, `S_EXEC`, `S_HALT`);
  - `DATA_W` and `ADDR_W` defaults.
- No sub-module. The ALU and memory are instantiated beside `control_unit` in `cpu_top`, not inside it.
- Implementation: one registered state/datapath process plus one combinational output decode.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with a STORE in memory → `mem_we`=`mem_re`=0 throughout; `pc`=0, `acc`=0. The first cycle after release shows `mem_re=1`, `mem_addr=0`.
- Arithmetic: M[0..2] = LOAD 0x010, ADD 0x011, STORE 0x012; M[0x010]=9, M[0x011]=3 → M[0x012]=12 after 13 cycles; `alu_op`=0001 during EXEC.
- Zero flag and branch: LOAD 5; SUB 5; JZ 0x020 → `acc`=0, `z`=1, `pc`=0x020. Repeat with SUB 3 → `acc`=2, JZ not taken, `pc`=3.
- Logic ops: `acc`=0x000F with M=0x0007 → AND gives 0x0007, OR gives 0x000F, XOR gives 0x0008; NOT on 0x000F gives 0xFFF0 in 4 cycles.
- Boundaries:
  - `RESET_PC`=0xFFF with a NOP there → next fetch address 0x000.
  - Opcode 1100 behaves as NOP (3 cycles, no state change).
  - HALT → `halted`=1 and no further `mem_re` for 20 cycles.
- Mid-instruction reset: assert `rst_n`=0 during the OPERAND cycle of an ADD → `acc` unchanged from 0, and execution restarts at `RESET_PC`.
